// File: rtl/mem_port_scheduler_if.sv
// Client-side and memory-side signal bundle for the shared memory port scheduler.
// The slave modport is the scheduler view; master is the clients/memory view.
interface mem_port_scheduler_if #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    logic [NUM_CLIENTS-1:0]            requests;
    logic [NUM_CLIENTS-1:0]            req_wr;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CLIENTS-1:0]            grants;
    logic [NUM_CLIENTS-1:0]            done;
    logic [DATA_WIDTH-1:0]             rdata;
    logic                              err;
    logic                              mem_req;
    logic                              mem_wr;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic                              mem_ack;
    logic [DATA_WIDTH-1:0]             mem_rdata;

    modport slave (
        input  requests, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
        output grants, done, rdata, err, mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output requests, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
        input  grants, done, rdata, err, mem_req, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_scheduler.sv
// Round-robin arbiter granting one client at a time onto a single memory port,
// with an ack timeout that completes the transaction with an error flag.
module mem_port_scheduler #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_scheduler_if.slave   bus
);
    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]             state_q,     state_d;
    logic [NUM_CLIENTS-1:0] grants_q,    grants_d;
    logic [NUM_CLIENTS-1:0] done_q,      done_d;
    logic                   err_q,       err_d;
    logic [DATA_WIDTH-1:0]  rdata_q,     rdata_d;
    logic                   mem_req_q,   mem_req_d;
    logic                   mem_wr_q,    mem_wr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [IDX_W-1:0]       win_q,       win_d;
    logic [IDX_W-1:0]       last_q,      last_d;

    logic                   hi_vld_c, lo_vld_c;
    logic [IDX_W-1:0]       hi_idx_c, lo_idx_c, pick_idx_c;
    logic                   sel_wr_c;
    logic [ADDR_WIDTH-1:0]  sel_addr_c;
    logic [DATA_WIDTH-1:0]  sel_wdata_c;

    // Round robin: lowest requester above last_q, else lowest requester overall.
    always_comb begin
        hi_vld_c = 1'b0;
        hi_idx_c = '0;
        lo_vld_c = 1'b0;
        lo_idx_c = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (!hi_vld_c && bus.requests[i] && (IDX_W'(i) > last_q)) begin
                hi_vld_c = 1'b1;
                hi_idx_c = IDX_W'(i);
            end
            if (!lo_vld_c && bus.requests[i]) begin
                lo_vld_c = 1'b1;
                lo_idx_c = IDX_W'(i);
            end
        end
        pick_idx_c = hi_vld_c ? hi_idx_c : lo_idx_c;
    end

    always_comb begin
        sel_wr_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (IDX_W'(i) == pick_idx_c) begin
                sel_wr_c    = bus.req_wr[i];
                sel_addr_c  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_c = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grants_d    = grants_q;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        last_d      = last_q;
        case (state_q)
            S_IDLE: begin
                grants_d  = '0;
                mem_req_d = 1'b0;
                if (lo_vld_c) begin
                    state_d     = S_ACCESS;
                    grants_d    = NUM_CLIENTS'(1) << pick_idx_c;
                    win_d       = pick_idx_c;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = sel_wr_c;
                    mem_addr_d  = sel_addr_c;
                    mem_wdata_d = sel_wdata_c;
                    cnt_d       = '0;
                end
            end
            S_ACCESS: begin
                // An ack arriving on the timeout cycle still completes cleanly.
                if (bus.mem_ack) begin
                    if (!mem_wr_q) rdata_d = bus.mem_rdata;
                    mem_req_d = 1'b0;
                    done_d    = grants_q;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        mem_req_d = 1'b0;
                        done_d    = grants_q;
                        err_d     = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                grants_d = '0;
                last_d   = win_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                grants_d  = '0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grants_q    <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            win_q       <= '0;
            last_q      <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            state_q     <= state_d;
            grants_q    <= grants_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            last_q      <= last_d;
        end
    end

    assign bus.grants    = grants_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
